// File: rtl/led_blink_ctrl_pkg.sv
// led_blink_ctrl_pkg: shared state encoding and default widths for the LED blink sequencer
package led_blink_ctrl_pkg;
  localparam int CNT_W_DEF = 29;
  localparam int REP_W_DEF = 4;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;
endpackage

// File: rtl/led_phase_timer.sv
// led_phase_timer: phase counter with clear, enable and terminal flag at limit-1
module led_phase_timer #(
  parameter int CNT_W = 29
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             term
);
  logic [CNT_W-1:0] r_count;
  // counts up while enabled; clear wins so the next phase starts at zero
  always_ff @(posedge clk) begin
    if (!rst_n || clr) r_count <= '0;
    else if (en) r_count <= r_count + CNT_W'(1);
  end
  // equality compare; limit is never zero so limit-1 cannot wrap
  assign term  = r_count == limit - CNT_W'(1);
  assign count = r_count;
endmodule

// File: rtl/led_blink_ctrl.sv
// led_blink_ctrl: accepts blink jobs and sequences the LED through ON/OFF phases
module led_blink_ctrl
  import led_blink_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int REP_W = REP_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_on_ticks,
  input  logic [CNT_W-1:0] cfg_off_ticks,
  input  logic [REP_W-1:0] cfg_repeat,
  input  logic             abort,
  output logic             led,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done
);
  state_t           r_state;
  logic             r_led, r_busy, r_done;
  logic [CNT_W-1:0] r_on, r_off;
  logic [REP_W-1:0] r_rep, r_per;
  logic [CNT_W-1:0] w_limit;
  logic             w_term, w_clr;

  assign w_limit = (r_state == S_ON) ? r_on : r_off;
  assign w_clr   = (r_state == S_IDLE) | abort | w_term;

  led_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clr),
    .en    (r_busy),
    .limit (w_limit),
    .count (count),
    .term  (w_term)
  );

  // job sequencer: latch job on accept, walk ON/OFF phases, count finished periods
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_led   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_on    <= '0;
      r_off   <= '0;
      r_rep   <= '0;
      r_per   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (cfg_valid && !abort) begin
          r_on    <= (cfg_on_ticks == '0) ? CNT_W'(1) : cfg_on_ticks;
          r_off   <= (cfg_off_ticks == '0) ? CNT_W'(1) : cfg_off_ticks;
          r_rep   <= cfg_repeat;
          r_per   <= '0;
          r_state <= S_ON;
          r_led   <= 1'b1;
          r_busy  <= 1'b1;
        end
        S_ON: if (abort) begin
          r_state <= S_IDLE;
          r_led   <= 1'b0;
          r_busy  <= 1'b0;
        end else if (w_term) begin
          r_state <= S_OFF;
          r_led   <= 1'b0;
        end
        S_OFF: if (abort) begin
          r_state <= S_IDLE;
          r_led   <= 1'b0;
          r_busy  <= 1'b0;
        end else if (w_term) begin
          if (r_rep == '0 || r_per < r_rep - REP_W'(1)) begin
            r_state <= S_ON;
            r_led   <= 1'b1;
            if (r_rep != '0) r_per <= r_per + REP_W'(1);
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_led   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready = r_state == S_IDLE;
  assign led       = r_led;
  assign busy      = r_busy;
  assign done      = r_done;
endmodule
